// File: rtl/tl_pkg.sv
// TileLink-UL opcodes shared by the width widgets and the beats-per-wide-beat helper.
package tl_pkg;

  typedef enum logic [2:0] {
    PUT_FULL_DATA    = 3'd0,
    PUT_PARTIAL_DATA = 3'd1,
    GET              = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  // Narrow beats making up one wide beat: 2^(size-lg) clamped to [1, r].
  function automatic int unsigned tl_bpb(input logic        multi,
                                         input int unsigned size,
                                         input int unsigned lg,
                                         input int unsigned r);
    int unsigned beats;
    beats = 1;
    if (multi && (size > lg)) begin
      if ((size - lg) >= 16) beats = r;
      else                   beats = 32'd1 << (size - lg);
      if (beats > r) beats = r;
    end
    return beats;
  endfunction

endpackage

// File: rtl/tl_d_beat_merger.sv
// Merges narrow D-channel beats into one wide beat; sub-width responses are replicated across lanes.
module tl_d_beat_merger
  import tl_pkg::*;
#(
  parameter int unsigned OUT_BYTES = 4,
  parameter int unsigned R         = 2,
  parameter int unsigned SIZE_W    = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [2:0]               i_opcode,
  input  logic [SIZE_W-1:0]        i_size,
  input  logic [8*OUT_BYTES-1:0]   i_data,
  input  logic                     i_denied,
  input  logic                     i_corrupt,
  input  logic                     i_ready_up,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [R*8*OUT_BYTES-1:0] o_data,
  output logic                     o_denied,
  output logic                     o_corrupt
);

  localparam int unsigned OUT_W = 8 * OUT_BYTES;
  localparam int unsigned LG    = $clog2(OUT_BYTES);
  localparam int unsigned CNT_W = $clog2(R);

  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_buf [R-1];
  logic             r_denied;
  logic             r_corrupt;

  logic [CNT_W-1:0] w_bpb_m1;
  logic             w_last;
  logic             w_fire;

  assign w_bpb_m1 = CNT_W'(tl_bpb(i_opcode == ACCESS_ACK_DATA, 32'(i_size), LG, R) - 1);
  assign w_last   = (r_cnt == w_bpb_m1);
  assign o_valid  = i_valid & w_last;
  assign o_ready  = w_last ? i_ready_up : 1'b1;
  assign w_fire   = i_valid & o_ready;

  assign o_denied  = r_denied  | i_denied;
  assign o_corrupt = r_corrupt | i_corrupt;

  // Non-final beats are parked in their lane slot; the final beat emits and clears.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_denied  <= 1'b0;
      r_corrupt <= 1'b0;
      for (int e = 0; e < int'(R) - 1; e++) r_buf[e] <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_cnt     <= '0;
        r_denied  <= 1'b0;
        r_corrupt <= 1'b0;
      end else begin
        r_cnt     <= r_cnt + CNT_W'(1);
        r_denied  <= r_denied | i_denied;
        r_corrupt <= r_corrupt | i_corrupt;
        for (int e = 0; e < int'(R) - 1; e++) begin
          if (r_cnt == CNT_W'(e)) r_buf[e] <= i_data;
        end
      end
    end
  end

  // Lane j takes group slot (j mod bpb); the top slot of the group is the live beat.
  always_comb begin
    o_data = '0;
    for (int j = 0; j < int'(R); j++) begin : g_lane
      logic [CNT_W-1:0] slot;
      logic [OUT_W-1:0] word;
      slot = CNT_W'(j) & w_bpb_m1;
      word = i_data;
      for (int e = 0; e < int'(R) - 1; e++) begin
        if ((slot != w_bpb_m1) && (slot == CNT_W'(e))) word = r_buf[e];
      end
      o_data[j*OUT_W +: OUT_W] = word;
    end
  end

endmodule

// File: rtl/tl_width_widget_down.sv
// TileLink-UL wide-to-narrow width converter: splits A data beats, merges D AccessAckData beats.
module tl_width_widget_down
  import tl_pkg::*;
#(
  parameter int unsigned IN_BYTES  = 8,
  parameter int unsigned OUT_BYTES = 4,
  parameter int unsigned ADDR_W    = 31,
  parameter int unsigned SOURCE_W  = 8,
  parameter int unsigned SIZE_W    = 3
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   in_a_valid,
  output logic                   in_a_ready,
  input  logic [2:0]             in_a_opcode,
  input  logic [2:0]             in_a_param,
  input  logic [SIZE_W-1:0]      in_a_size,
  input  logic [SOURCE_W-1:0]    in_a_source,
  input  logic [ADDR_W-1:0]      in_a_address,
  input  logic [IN_BYTES-1:0]    in_a_mask,
  input  logic [8*IN_BYTES-1:0]  in_a_data,
  input  logic                   in_a_corrupt,

  output logic                   in_d_valid,
  input  logic                   in_d_ready,
  output logic [2:0]             in_d_opcode,
  output logic [1:0]             in_d_param,
  output logic [SIZE_W-1:0]      in_d_size,
  output logic [SOURCE_W-1:0]    in_d_source,
  output logic                   in_d_sink,
  output logic                   in_d_denied,
  output logic [8*IN_BYTES-1:0]  in_d_data,
  output logic                   in_d_corrupt,

  output logic                   out_a_valid,
  input  logic                   out_a_ready,
  output logic [2:0]             out_a_opcode,
  output logic [2:0]             out_a_param,
  output logic [SIZE_W-1:0]      out_a_size,
  output logic [SOURCE_W-1:0]    out_a_source,
  output logic [ADDR_W-1:0]      out_a_address,
  output logic [OUT_BYTES-1:0]   out_a_mask,
  output logic [8*OUT_BYTES-1:0] out_a_data,
  output logic                   out_a_corrupt,

  input  logic                   out_d_valid,
  output logic                   out_d_ready,
  input  logic [2:0]             out_d_opcode,
  input  logic [1:0]             out_d_param,
  input  logic [SIZE_W-1:0]      out_d_size,
  input  logic [SOURCE_W-1:0]    out_d_source,
  input  logic                   out_d_sink,
  input  logic                   out_d_denied,
  input  logic [8*OUT_BYTES-1:0] out_d_data,
  input  logic                   out_d_corrupt
);

  localparam int unsigned R     = IN_BYTES / OUT_BYTES;
  localparam int unsigned CNT_W = $clog2(R);
  localparam int unsigned LG    = $clog2(OUT_BYTES);
  localparam int unsigned IN_LG = $clog2(IN_BYTES);
  localparam int unsigned OUT_W = 8 * OUT_BYTES;

  logic [CNT_W-1:0] r_a_cnt;
  logic [CNT_W-1:0] w_a_bpb_m1;
  logic [CNT_W-1:0] w_a_lane;
  logic             w_a_last;
  logic             w_a_fire;

  assign w_a_bpb_m1 = CNT_W'(tl_bpb(in_a_opcode != GET, 32'(in_a_size), LG, R) - 1);
  assign w_a_last   = (r_a_cnt == w_a_bpb_m1);
  assign w_a_fire   = in_a_valid & out_a_ready;
  assign w_a_lane   = in_a_address[IN_LG-1:LG] + r_a_cnt;

  // Narrow-beat index within the current wide beat; wraps per wide beat of a burst.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        r_a_cnt <= '0;
    else if (w_a_fire) r_a_cnt <= w_a_last ? '0 : r_a_cnt + CNT_W'(1);
  end

  assign out_a_valid   = in_a_valid;
  assign in_a_ready    = out_a_ready & w_a_last;
  assign out_a_opcode  = in_a_opcode;
  assign out_a_param   = in_a_param;
  assign out_a_size    = in_a_size;
  assign out_a_source  = in_a_source;
  assign out_a_address = in_a_address;
  assign out_a_corrupt = in_a_corrupt;
  assign out_a_data    = in_a_data[32'(w_a_lane)*OUT_W +: OUT_W];
  assign out_a_mask    = in_a_mask[32'(w_a_lane)*OUT_BYTES +: OUT_BYTES];

  tl_d_beat_merger #(
    .OUT_BYTES (OUT_BYTES),
    .R         (R),
    .SIZE_W    (SIZE_W)
  ) u_d_merge (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_valid    (out_d_valid),
    .i_opcode   (out_d_opcode),
    .i_size     (out_d_size),
    .i_data     (out_d_data),
    .i_denied   (out_d_denied),
    .i_corrupt  (out_d_corrupt),
    .i_ready_up (in_d_ready),
    .o_ready    (out_d_ready),
    .o_valid    (in_d_valid),
    .o_data     (in_d_data),
    .o_denied   (in_d_denied),
    .o_corrupt  (in_d_corrupt)
  );

  assign in_d_opcode = out_d_opcode;
  assign in_d_param  = out_d_param;
  assign in_d_size   = out_d_size;
  assign in_d_source = out_d_source;
  assign in_d_sink   = out_d_sink;

endmodule

// File: tb/tb_tl_width_widget_down.sv
// Directed scoreboard bench for the 64-to-32-bit TileLink width converter.
module tb_tl_width_widget_down;
  import tl_pkg::*;

  localparam int unsigned IN_BYTES  = 8;
  localparam int unsigned OUT_BYTES = 4;
  localparam int unsigned ADDR_W    = 31;
  localparam int unsigned SOURCE_W  = 8;
  localparam int unsigned SIZE_W    = 3;

  logic clock = 1'b0;
  logic reset;

  logic                   in_a_valid, in_a_ready, in_a_corrupt;
  logic [2:0]             in_a_opcode, in_a_param;
  logic [SIZE_W-1:0]      in_a_size;
  logic [SOURCE_W-1:0]    in_a_source;
  logic [ADDR_W-1:0]      in_a_address;
  logic [IN_BYTES-1:0]    in_a_mask;
  logic [8*IN_BYTES-1:0]  in_a_data;

  logic                   in_d_valid, in_d_ready, in_d_sink, in_d_denied, in_d_corrupt;
  logic [2:0]             in_d_opcode;
  logic [1:0]             in_d_param;
  logic [SIZE_W-1:0]      in_d_size;
  logic [SOURCE_W-1:0]    in_d_source;
  logic [8*IN_BYTES-1:0]  in_d_data;

  logic                   out_a_valid, out_a_ready, out_a_corrupt;
  logic [2:0]             out_a_opcode, out_a_param;
  logic [SIZE_W-1:0]      out_a_size;
  logic [SOURCE_W-1:0]    out_a_source;
  logic [ADDR_W-1:0]      out_a_address;
  logic [OUT_BYTES-1:0]   out_a_mask;
  logic [8*OUT_BYTES-1:0] out_a_data;

  logic                   out_d_valid, out_d_ready, out_d_sink, out_d_denied, out_d_corrupt;
  logic [2:0]             out_d_opcode;
  logic [1:0]             out_d_param;
  logic [SIZE_W-1:0]      out_d_size;
  logic [SOURCE_W-1:0]    out_d_source;
  logic [8*OUT_BYTES-1:0] out_d_data;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    logic        rdy;
    logic [30:0] addr;
  } a_exp_t;

  typedef struct {
    logic [63:0] data;
    logic        corrupt;
    logic        denied;
    logic [7:0]  source;
  } d_exp_t;

  a_exp_t a_q[$];
  d_exp_t d_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  tl_width_widget_down #(
    .IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES), .ADDR_W(ADDR_W),
    .SOURCE_W(SOURCE_W), .SIZE_W(SIZE_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
    .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .in_a_corrupt(in_a_corrupt),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
    .in_d_param(in_d_param), .in_d_size(in_d_size), .in_d_source(in_d_source),
    .in_d_sink(in_d_sink), .in_d_denied(in_d_denied), .in_d_data(in_d_data),
    .in_d_corrupt(in_d_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_a_corrupt(out_a_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_data(out_d_data),
    .out_d_corrupt(out_d_corrupt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] data, input logic [3:0] mask,
                        input logic rdy, input logic [30:0] addr);
    a_exp_t e;
    e.data = data; e.mask = mask; e.rdy = rdy; e.addr = addr;
    a_q.push_back(e);
  endtask

  task automatic push_d(input logic [63:0] data, input logic corrupt,
                        input logic denied, input logic [7:0] source);
    d_exp_t e;
    e.data = data; e.corrupt = corrupt; e.denied = denied; e.source = source;
    d_q.push_back(e);
  endtask

  // A narrow beat is checked whenever it fires on the manager side.
  always @(negedge clock) begin
    if (reset && out_a_valid && out_a_ready) begin
      chk("a_q_nonempty", 64'(a_q.size() != 0), 64'd1);
      if (a_q.size() != 0) begin
        a_exp_t e;
        e = a_q.pop_front();
        chk("a_data", 64'(out_a_data), 64'(e.data));
        chk("a_mask", 64'(out_a_mask), 64'(e.mask));
        chk("a_in_ready", 64'(in_a_ready), 64'(e.rdy));
        chk("a_address", 64'(out_a_address), 64'(e.addr));
      end
    end
  end

  // A wide D beat is checked whenever it fires on the client side.
  always @(negedge clock) begin
    if (reset && in_d_valid && in_d_ready) begin
      chk("d_q_nonempty", 64'(d_q.size() != 0), 64'd1);
      if (d_q.size() != 0) begin
        d_exp_t e;
        e = d_q.pop_front();
        chk("d_data", in_d_data, e.data);
        chk("d_corrupt", 64'(in_d_corrupt), 64'(e.corrupt));
        chk("d_denied", 64'(in_d_denied), 64'(e.denied));
        chk("d_source", 64'(in_d_source), 64'(e.source));
      end
    end
  end

  task automatic a_send(input logic [2:0] op, input logic [2:0] sz, input logic [30:0] addr,
                        input logic [63:0] data, input logic [7:0] mask);
    int cyc;
    in_a_opcode = op; in_a_size = sz; in_a_address = addr;
    in_a_data = data; in_a_mask = mask; in_a_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!in_a_ready && cyc < 20);
    chk("a_accept", 64'(in_a_ready), 64'd1);
    @(posedge clock); #1;
    in_a_valid = 1'b0;
  endtask

  task automatic d_send(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] data,
                        input logic corrupt, input logic denied, input logic [7:0] source);
    int cyc;
    out_d_opcode = op; out_d_size = sz; out_d_data = data;
    out_d_corrupt = corrupt; out_d_denied = denied; out_d_source = source;
    out_d_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!out_d_ready && cyc < 20);
    chk("d_accept", 64'(out_d_ready), 64'd1);
    @(posedge clock); #1;
    out_d_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    in_a_valid = 1'b0; in_a_opcode = PUT_FULL_DATA; in_a_param = 3'd0; in_a_size = 3'd3;
    in_a_source = 8'h5A; in_a_address = 31'h0; in_a_mask = 8'hFF;
    in_a_data = 64'h0123456789ABCDEF; in_a_corrupt = 1'b0;
    out_a_ready = 1'b1; in_d_ready = 1'b0;
    out_d_valid = 1'b1; out_d_opcode = ACCESS_ACK_DATA; out_d_param = 2'd0; out_d_size = 3'd3;
    out_d_source = 8'h00; out_d_sink = 1'b0; out_d_denied = 1'b0; out_d_data = 32'h0;
    out_d_corrupt = 1'b0;

    // Reset-state outputs
    #12;
    chk("rst_in_a_ready_size3", 64'(in_a_ready), 64'd0);
    chk("rst_out_a_valid", 64'(out_a_valid), 64'd0);
    chk("rst_out_a_data_lane0", 64'(out_a_data), 64'h89ABCDEF);
    chk("rst_in_d_valid_size3", 64'(in_d_valid), 64'd0);
    chk("rst_out_d_ready_size3", 64'(out_d_ready), 64'd1);
    in_a_size = 3'd2; in_a_valid = 1'b1; out_d_size = 3'd2; in_d_ready = 1'b1;
    #1;
    chk("rst_in_a_ready_size2", 64'(in_a_ready), 64'd1);
    chk("rst_out_a_valid_follow", 64'(out_a_valid), 64'd1);
    chk("rst_in_d_valid_size2", 64'(in_d_valid), 64'd1);
    in_a_valid = 1'b0; out_d_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // PutFull size 3 split into two narrow beats
    push_a(32'h55667788, 4'hF, 1'b0, 31'h100);
    push_a(32'h11223344, 4'hF, 1'b1, 31'h100);
    a_send(PUT_FULL_DATA, 3'd3, 31'h100, 64'h1122334455667788, 8'hFF);

    // PutFull size 2 at the upper lane
    push_a(32'hDEADBEEF, 4'hF, 1'b1, 31'h104);
    a_send(PUT_FULL_DATA, 3'd2, 31'h104, 64'hDEADBEEF_00000000, 8'hF0);

    // Get size 3 is a single narrow beat
    push_a(32'h0BADC0DE, 4'hC, 1'b1, 31'h200);
    a_send(GET, 3'd3, 31'h200, 64'hCAFEF00D_0BADC0DE, 8'h3C);

    // Two-wide-beat burst restarts from lane 0 on each wide beat
    push_a(32'hA0A0A0A0, 4'hF, 1'b0, 31'h300);
    push_a(32'hA1A1A1A1, 4'h3, 1'b1, 31'h300);
    push_a(32'hB0B0B0B0, 4'hC, 1'b0, 31'h300);
    push_a(32'hB1B1B1B1, 4'hF, 1'b1, 31'h300);
    a_send(PUT_PARTIAL_DATA, 3'd4, 31'h300, 64'hA1A1A1A1_A0A0A0A0, 8'h3F);
    a_send(PUT_PARTIAL_DATA, 3'd4, 31'h300, 64'hB1B1B1B1_B0B0B0B0, 8'hFC);

    // AccessAckData size 3 with client stalled; first beat must still be absorbed
    in_d_ready = 1'b0;
    push_d(64'hBBBBBBBB_AAAAAAAA, 1'b1, 1'b0, 8'h33);
    out_d_valid = 1'b1; out_d_opcode = ACCESS_ACK_DATA; out_d_size = 3'd3;
    out_d_data = 32'hAAAAAAAA; out_d_corrupt = 1'b0; out_d_denied = 1'b0; out_d_source = 8'h33;
    @(negedge clock);
    chk("d_first_absorbed", 64'(out_d_ready), 64'd1);
    chk("d_first_hidden", 64'(in_d_valid), 64'd0);
    @(posedge clock); #1;
    out_d_data = 32'hBBBBBBBB; out_d_corrupt = 1'b1;
    @(negedge clock);
    chk("d_last_valid", 64'(in_d_valid), 64'd1);
    chk("d_last_stalled", 64'(out_d_ready), 64'd0);
    @(posedge clock); #1;
    in_d_ready = 1'b1;
    @(posedge clock); #1;
    out_d_valid = 1'b0; out_d_corrupt = 1'b0;

    // Sub-width AccessAckData is replicated into both lanes
    push_d(64'h12345678_12345678, 1'b0, 1'b0, 8'h44);
    d_send(ACCESS_ACK_DATA, 3'd2, 32'h12345678, 1'b0, 1'b0, 8'h44);

    // AccessAck is always a single beat; denied on it passes through
    push_d(64'h00000000_00000000, 1'b0, 1'b1, 8'h55);
    d_send(ACCESS_ACK, 3'd3, 32'h0, 1'b0, 1'b1, 8'h55);

    // Denied on the first beat is sticky to the wide beat
    push_d(64'h00000002_00000001, 1'b0, 1'b1, 8'h66);
    d_send(ACCESS_ACK_DATA, 3'd3, 32'h1, 1'b0, 1'b1, 8'h66);
    d_send(ACCESS_ACK_DATA, 3'd3, 32'h2, 1'b0, 1'b0, 8'h66);

    // Reset after the first narrow beat of a Put, then a fresh Put
    push_a(32'hB1B2B3B4, 4'hF, 1'b0, 31'h100);
    in_a_opcode = PUT_FULL_DATA; in_a_size = 3'd3; in_a_address = 31'h100;
    in_a_data = 64'hA1A2A3A4_B1B2B3B4; in_a_mask = 8'hFF; in_a_valid = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b0; in_a_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    push_a(32'h0C0D0E0F, 4'hF, 1'b0, 31'h100);
    push_a(32'h08090A0B, 4'hF, 1'b1, 31'h100);
    a_send(PUT_FULL_DATA, 3'd3, 31'h100, 64'h08090A0B_0C0D0E0F, 8'hFF);

    // Reset after the first narrow beat of an ack, then a fresh ack
    d_send(ACCESS_ACK_DATA, 3'd3, 32'hDEAD0001, 1'b1, 1'b1, 8'h77);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    push_d(64'h22222222_11111111, 1'b0, 1'b0, 8'h88);
    d_send(ACCESS_ACK_DATA, 3'd3, 32'h11111111, 1'b0, 1'b0, 8'h88);
    d_send(ACCESS_ACK_DATA, 3'd3, 32'h22222222, 1'b0, 1'b0, 8'h88);

    repeat (3) @(posedge clock);
    #1;
    chk("a_q_drained", 64'(a_q.size()), 64'd0);
    chk("d_q_drained", 64'(d_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
